// File: rtl/genius_pkg.sv
// Shared definitions for the game controller, datapath and playback sequencer:
// playback state encoding, sequence depth and LED pattern width.
package genius_pkg;

    localparam int MAX_LEN = 16;
    localparam int LED_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ON    = 3'd3,
        ST_OFF   = 3'd4,
        ST_FIN   = 3'd5
    } play_state_t;

endpackage

// File: rtl/genius_playback_ctrl_if.sv
// Sequence memory read port between the playback sequencer (master) and the
// datapath sequence RAM (slave). Read data is valid the cycle after mem_rd.
interface genius_playback_ctrl_if #(
    parameter int AW = 4
);
    logic                          mem_rd;
    logic [AW-1:0]                 mem_addr;
    logic [genius_pkg::LED_W-1:0]  mem_data;

    modport master (output mem_rd, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/genius_down_timer.sv
// Loadable down-counter; tc flags the last cycle of a loaded interval (count == 1).
// Load wins over enable, and the count stops at zero instead of wrapping.
module genius_down_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == W'(1));
endmodule

// File: rtl/genius_playback_ctrl.sv
// Plays the stored colour sequence on the game LEDs, then pulses done (end_FPGA).
// Optional GENIUS_PLAYBACK_SPEEDUP_EN shortens the on-time for long sequences.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | read strobe for element at index
// LOAD  | capture read data into leds, load on-time
// ON    | element lit
// OFF   | blank gap after element
// FIN   | one-cycle done pulse
module genius_playback_ctrl #(
    parameter int ON_TICKS  = 25000000,
    parameter int OFF_TICKS = 12500000,
    parameter int MAX_LEN   = genius_pkg::MAX_LEN,
    parameter int AW        = 4
) (
    input  logic                          CLOCK,
    input  logic                          reset,
    input  logic                          start,
    input  logic [4:0]                    len,
    genius_playback_ctrl_if.master        mem,
    output logic [genius_pkg::LED_W-1:0]  leds,
    output logic                          busy,
    output logic                          done
);
    import genius_pkg::*;

    localparam int TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW       = $clog2(TICK_MAX + 1);

    play_state_t   state, state_next;
    logic [AW-1:0] index;
    logic [4:0]    eff_len, len_sat;
    logic [TW-1:0] on_time, tmr_val;
    logic          tmr_load, tmr_tc;

    assign len_sat = (len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : len;

`ifdef GENIUS_PLAYBACK_SPEEDUP_EN
    // eff_len[4:3] selects full / half / quarter on-time; never below one cycle
    logic [TW-1:0] on_shift;
    assign on_shift = TW'(ON_TICKS) >> eff_len[4:3];
    assign on_time  = (on_shift == '0) ? TW'(1) : on_shift;
`else
    assign on_time = TW'(ON_TICKS);
`endif

    genius_down_timer #(.W(TW)) u_timer (
        .clk      (CLOCK),
        .rst      (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (1'b1),
        .tc       (tmr_tc)
    );

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_val    = on_time;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len_sat == 5'd0) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_LOAD;
            ST_LOAD: begin
                tmr_load   = 1'b1;
                state_next = ST_ON;
            end
            ST_ON: begin
                if (tmr_tc) begin
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(OFF_TICKS);
                    state_next = ST_OFF;
                end
            end
            ST_OFF: begin
                if (tmr_tc) begin
                    state_next = (5'(index) == eff_len - 5'd1) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            index   <= '0;
            eff_len <= '0;
            leds    <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                index   <= '0;
                eff_len <= len_sat;
            end
            if (state == ST_LOAD) begin
                leds <= mem.mem_data;
            end
            if (state == ST_ON && tmr_tc) begin
                leds <= '0;
            end
            if (state == ST_OFF && state_next == ST_FETCH) begin
                index <= index + AW'(1);
            end
        end
    end

    // index only moves on edges entering FETCH, so the address holds between reads
    assign mem.mem_rd   = (state == ST_FETCH);
    assign mem.mem_addr = index;
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_FIN);
endmodule

// File: tb/tb_genius_playback_ctrl.sv
// Scoreboard bench for genius_playback_ctrl with ON_TICKS=4, OFF_TICKS=2.
// Cycle numbers are relative to the cycle in which start is driven high.
module tb_genius_playback_ctrl;
    localparam int ON_T  = 4;
    localparam int OFF_T = 2;
    localparam int AW    = 4;

    logic       CLOCK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] len   = 5'd0;
    logic [3:0] leds;
    logic       busy, done;

    genius_playback_ctrl_if #(.AW(AW)) mif ();

    genius_playback_ctrl #(
        .ON_TICKS  (ON_T),
        .OFF_TICKS (OFF_T),
        .MAX_LEN   (16),
        .AW        (AW)
    ) dut (
        .CLOCK (CLOCK),
        .reset (reset),
        .start (start),
        .len   (len),
        .mem   (mif),
        .leds  (leds),
        .busy  (busy),
        .done  (done)
    );

    always #5 CLOCK = ~CLOCK;

    logic [3:0] mem [16];
    always @(posedge CLOCK) begin
        if (mif.mem_rd === 1'b1) mif.mem_data <= mem[mif.mem_addr];
    end

    int cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef enum int {EV_RD = 0, EV_LED = 1, EV_DONE = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
        int       cyc;
        int       dur;
    } ev_t;

    ev_t exp_q[$];
    int  t0 = 0;
    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 1'b0;
    bit  chk_idle = 1'b0;
    int  drain_req = 0;
    int  drain_seen = 0;

    function automatic int exp_on(int n);
`ifdef GENIUS_PLAYBACK_SPEEDUP_EN
        if (n >= 16) return 1;
        if (n >= 8) return 2;
        return 4;
`else
        return (n >= 0) ? 4 : 4;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc - t0);
        end
    endtask

    task automatic pop_cmp(input ev_t got);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind=%0d val=%0d cycle=%0d expected no event",
                     got.kind, got.val, got.cyc);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", got.kind, e.kind);
            check("event_value", got.val, e.val);
            check("event_cycle", got.cyc, e.cyc);
            if (e.kind == EV_LED) check("led_duration", got.dur, e.dur);
        end
    endtask

    logic [3:0] prev_leds = 4'd0;
    logic       prev_done = 1'b0;
    int         lit_start = 0;

    // monitor: turns DUT activity into events and compares them in order
    always @(negedge CLOCK) begin
        ev_t g;
        int  rel;
        if (mon_en) begin
            rel = cyc - t0;
            if (drain_req != drain_seen) begin
                check("queue_drained", exp_q.size(), 0);
                exp_q.delete();
                drain_seen = drain_req;
            end
            if (chk_idle) begin
                check("idle_leds", leds, 0);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_mem_rd", mif.mem_rd, 0);
            end
            if (mif.mem_rd === 1'b1) begin
                g.kind = EV_RD; g.val = int'(mif.mem_addr); g.cyc = rel; g.dur = 0;
                pop_cmp(g);
            end
            if (leds !== prev_leds) begin
                if (prev_leds != 4'd0) begin
                    g.kind = EV_LED; g.val = int'(prev_leds); g.cyc = lit_start; g.dur = rel - lit_start;
                    pop_cmp(g);
                end
                lit_start = rel;
                prev_leds = leds;
            end
            if (prev_done === 1'b1) check("busy_after_done", busy, 0);
            if (done === 1'b1) begin
                g.kind = EV_DONE; g.val = int'(busy); g.cyc = rel; g.dur = 0;
                pop_cmp(g);
            end
            prev_done = done;
        end
    end

    task automatic push_ev(input ev_kind_t k, input int v, input int c, input int d);
        ev_t e;
        e.kind = k; e.val = v; e.cyc = c; e.dur = d;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(posedge CLOCK);
            guard++;
        end
        repeat (3) @(posedge CLOCK);
        #1;
        drain_req++;
        @(posedge CLOCK);
        #1;
    endtask

    // element k: read at 1+per*k, lit from 3+per*k for on-time; done at eff*per+1
    task automatic play(input int n, input bit pulse_again);
        int eff, on, per;
        eff = (n > 16) ? 16 : n;
        on  = exp_on(eff);
        per = 2 + on + OFF_T;
        for (int k = 0; k < eff; k++) begin
            push_ev(EV_RD, k, 1 + per * k, 0);
            push_ev(EV_LED, int'(mem[k]), 3 + per * k, on);
        end
        push_ev(EV_DONE, 1, eff * per + 1, 0);
        @(posedge CLOCK);
        #1;
        len   = 5'(n);
        start = 1'b1;
        t0    = cyc;
        @(posedge CLOCK);
        #1;
        start = 1'b0;
        len   = 5'd31;
        if (pulse_again) begin
            repeat (9) @(posedge CLOCK);
            #1;
            start = 1'b1;
            @(posedge CLOCK);
            #1;
            start = 1'b0;
        end
        drain();
    endtask

    task automatic reset_mid();
        push_ev(EV_RD, 0, 1, 0);
        push_ev(EV_LED, int'(mem[0]), 3, 4);
        push_ev(EV_RD, 1, 9, 0);
        push_ev(EV_LED, int'(mem[1]), 11, 2);
        @(posedge CLOCK);
        #1;
        len   = 5'd3;
        start = 1'b1;
        t0    = cyc;
        @(posedge CLOCK);
        #1;
        start = 1'b0;
        repeat (11) @(posedge CLOCK);
        #1;
        reset = 1'b1;
        @(posedge CLOCK);
        #1;
        reset    = 1'b0;
        chk_idle = 1'b1;
        @(posedge CLOCK);
        #1;
        chk_idle = 1'b0;
        drain();
    endtask

    initial begin
        mem[0] = 4'd1;
        mem[1] = 4'd2;
        mem[2] = 4'd4;
        mem[3] = 4'd8;
        for (int i = 4; i < 16; i++) mem[i] = 4'((i % 15) + 1);
        mif.mem_data = 4'd0;

        repeat (3) @(posedge CLOCK);
        #1;
        reset    = 1'b0;
        t0       = cyc;
        mon_en   = 1'b1;
        chk_idle = 1'b1;
        repeat (20) @(posedge CLOCK);
        #1;
        chk_idle = 1'b0;

        play(3, 1'b0);
        play(0, 1'b0);
        play(20, 1'b0);
        play(3, 1'b1);
        reset_mid();
        play(2, 1'b0);
        play(8, 1'b0);
        play(16, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
